instruction_loader: RTL

Boot-time program loader that fills the instruction memory from a byte stream. It accepts a length-prefixed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word goes out as a one-cycle write to the instruction memory's write port. The processor is held in reset (`CpuHold`) until the load completes cleanly.

---
 rtl/instruction_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/instruction_loader.sv
// Boot loader: length-prefixed byte stream -> little-endian 32-bit instruction memory writes.
// Optional trailer checksum byte is compiled in with `define LOADER_CHECKSUM_EN.
module instruction_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Start,
  input  logic [7:0]           InByte,
  input  logic                 InValid,
  output logic                 InReady,
  output logic                 MemWrite,
  output logic [31:0]          MemAddress,
  output logic [31:0]          MemWriteData,
  output logic [ADDR_BITS:0]   WordCount,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Error,
  output logic                 CpuHold
);

  localparam int unsigned WC_W = ADDR_BITS + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM = 3'd4,
`endif
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t            state_q, state_d, after_payload;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d, len_n;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_buf_q, word_buf_d;
  logic              accept;
  logic              in_ready_d, mem_write_d, busy_d, done_d, error_d, hold_d;
  logic [31:0]       mem_addr_d, mem_data_d;
  logic [WC_W-1:0]   wc_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign accept = InValid && InReady;
  assign len_n  = {InByte, len_lo_q};

  // Next-state, datapath and next-output decode
  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    word_buf_d  = word_buf_q;
    mem_write_d = 1'b0;
    mem_addr_d  = MemAddress;
    mem_data_d  = MemWriteData;
    wc_d        = WordCount;
`ifdef LOADER_CHECKSUM_EN
    csum_d        = csum_q;
    after_payload = S_CSUM;
`else
    after_payload = S_DONE;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          state_d    = S_LEN0;
          wc_d       = '0;
          byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_lo_d = InByte;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d = len_n;
          if (len_n == 16'd0)                 state_d = after_payload;
          else if (32'(len_n) > 32'(DEPTH))   state_d = S_ERR;
          else                                state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          byte_cnt_d = 2'(byte_cnt_q + 2'd1);
          word_buf_d = {InByte, word_buf_q[23:8]};
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ InByte;
`endif
          // Fourth byte completes the word: emit the write pulse and advance the count
          if (byte_cnt_q == 2'd3) begin
            mem_write_d = 1'b1;
            mem_data_d  = {InByte, word_buf_q};
            mem_addr_d  = 32'({WordCount[ADDR_BITS-1:0], 2'b00});
            wc_d        = WordCount + WC_W'(1);
            if ((16'(WordCount) + 16'd1) == len_q) state_d = after_payload;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) state_d = (InByte == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    busy_d = busy_d || (state_d == S_CSUM);
`endif
    in_ready_d = busy_d;
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    hold_d     = (state_d != S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      word_buf_q   <= '0;
      InReady      <= 1'b0;
      MemWrite     <= 1'b0;
      MemAddress   <= '0;
      MemWriteData <= '0;
      WordCount    <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
      CpuHold      <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      word_buf_q   <= word_buf_d;
      InReady      <= in_ready_d;
      MemWrite     <= mem_write_d;
      MemAddress   <= mem_addr_d;
      MemWriteData <= mem_data_d;
      WordCount    <= wc_d;
      Busy         <= busy_d;
      Done         <= done_d;
      Error        <= error_d;
      CpuHold      <= hold_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule
